// File: rtl/spram_ctrl.sv
// -----------------------------------------------------------------------------
// spram_ctrl
//
// Sequencing master for a single-port RAM with a one-cycle read latency.
// After reset, it fills every location with clear_value. It then serves single
// read/write accesses from one host over a req/ack handshake. The host can
// re-trigger the fill whenever the controller is idle.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high reset
//   clear_start  : request a full fill (sampled only when idle)
//   busy         : high whenever the controller is not idle
//   done         : one-cycle pulse when a fill completes
//   req/we       : host access request / write select (1 = write)
//   addr/wdata   : host address / write data
//   ack          : one-cycle pulse completing a host access
//   rdata        : read result, valid with ack and held afterwards
//   ram_address  : RAM address
//   ram_data     : RAM write data
//   ram_wren     : RAM write enable
//   ram_q        : RAM read data, valid the cycle after the address edge
// -----------------------------------------------------------------------------
module spram_ctrl #(
    parameter int                    address_width = 8,
    parameter int                    data_width    = 8,
    parameter logic [data_width-1:0] clear_value   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_start,
    output logic                     busy,
    output logic                     done,
    input  logic                     req,
    input  logic                     we,
    input  logic [address_width-1:0] addr,
    input  logic [data_width-1:0]    wdata,
    output logic                     ack,
    output logic [data_width-1:0]    rdata,
    output logic [address_width-1:0] ram_address,
    output logic [data_width-1:0]    ram_data,
    output logic                     ram_wren,
    input  logic [data_width-1:0]    ram_q
);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic [address_width-1:0] addr_zero = '0;
    localparam logic [address_width-1:0] addr_last = '1;
    localparam logic [address_width-1:0] addr_one  = address_width'(1);

    state_t                   state_r;
    state_t                   state_s;
    logic [address_width-1:0] address_s;
    logic [data_width-1:0]    data_s;
    logic                     wren_s;
    logic                     ack_s;
    logic                     done_s;
    logic                     busy_s;
    logic [data_width-1:0]    rdata_s;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_s   = state_r;
        address_s = ram_address;
        data_s    = ram_data;
        wren_s    = ram_wren;
        ack_s     = 1'b0;
        done_s    = 1'b0;
        rdata_s   = rdata;

        case (state_r)
            ST_START: begin
                state_s   = ST_CLEAR;
                address_s = addr_zero;
                data_s    = clear_value;
                wren_s    = 1'b1;
            end

            ST_CLEAR: begin
                // The write to the last address is issued on this edge, so the
                // counter stops here instead of wrapping.
                if (ram_address == addr_last) begin
                    wren_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    address_s = ram_address + addr_one;
                end
            end

            ST_IDLE: begin
                if (clear_start) begin
                    state_s   = ST_CLEAR;
                    address_s = addr_zero;
                    data_s    = clear_value;
                    wren_s    = 1'b1;
                end else if (req) begin
                    state_s   = ST_ACCESS;
                    address_s = addr;
                    data_s    = wdata;
                    wren_s    = we;
                end else begin
                    wren_s = 1'b0;
                end
            end

            ST_ACCESS: begin
                // The RAM performs the access on this edge. ram_q is valid in
                // the following cycle.
                wren_s  = 1'b0;
                state_s = ST_RESP;
            end

            ST_RESP: begin
                // The RAM is write-through, so ram_q holds the written word
                // after a write and the stored word after a read.
                ack_s   = 1'b1;
                rdata_s = ram_q;
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_START;
                wren_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers. busy follows the registered state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_START;
            ram_address <= addr_zero;
            ram_data    <= clear_value;
            ram_wren    <= 1'b0;
            ack         <= 1'b0;
            done        <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b1;
        end else begin
            state_r     <= state_s;
            ram_address <= address_s;
            ram_data    <= data_s;
            ram_wren    <= wren_s;
            ack         <= ack_s;
            done        <= done_s;
            rdata       <= rdata_s;
            busy        <= busy_s;
        end
    end

endmodule

// File: tb/tb_spram_ctrl.sv
module tb_spram_ctrl;

    localparam int         AW = 4;
    localparam int         DW = 8;
    localparam logic [7:0] CV = 8'hA5;

    logic          clk;
    logic          reset;
    logic          clear_start;
    logic          busy;
    logic          done;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    int n_checks = 0;
    int n_errors = 0;

    spram_ctrl #(
        .address_width (AW),
        .data_width    (DW),
        .clear_value   (CV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .busy        (busy),
        .done        (done),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rdata       (rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural write-through single-port RAM with a registered q.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_address] <= ram_data;
            ram_q            <= ram_data;
        end else begin
            ram_q <= mem[ram_address];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Checks one complete fill that begins on the next edge: 16 writes to
    // addresses 0..15, then done for a single cycle with busy low.
    task automatic check_fill(input string tag);
        for (int k = 0; k < (1 << AW); k++) begin
            @(negedge clk);
            clear_start = 1'b0;
            check_val({tag, " wren"}, 32'(ram_wren), 32'd1);
            check_val({tag, " addr"}, 32'(ram_address), 32'(k));
            check_val({tag, " data"}, 32'(ram_data), 32'(CV));
            check_val({tag, " nodone"}, 32'(done), 32'd0);
            check_val({tag, " noack"}, 32'(ack), 32'd0);
            check_val({tag, " busy"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        check_val({tag, " done"}, 32'(done), 32'd1);
        check_val({tag, " wren off"}, 32'(ram_wren), 32'd0);
        check_val({tag, " busy low"}, 32'(busy), 32'd0);
    endtask

    // Performs one host access and checks the ack latency. Call it at a
    // negedge while the controller is idle.
    task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input string tag, output logic [DW-1:0] rd);
        int n;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 50);
        check_val({tag, " latency"}, 32'(n), 32'd3);
        rd  = rdata;
        req = 1'b0;
    endtask

    logic [DW-1:0] rd;
    int            n;

    initial begin
        reset       = 1'b1;
        clear_start = 1'b0;
        req         = 1'b1;   // read of address 3 held from reset release
        we          = 1'b0;
        addr        = 4'd3;
        wdata       = 8'h00;

        @(negedge clk);
        @(negedge clk);
        check_val("rst addr", 32'(ram_address), 32'd0);
        check_val("rst data", 32'(ram_data), 32'(CV));
        check_val("rst wren", 32'(ram_wren), 32'd0);
        check_val("rst ack", 32'(ack), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst rdata", 32'(rdata), 32'd0);
        check_val("rst busy", 32'(busy), 32'd1);

        // Reset release, then the initial fill with a pending read.
        reset = 1'b0;
        check_fill("fill0");
        @(negedge clk);
        check_val("pend ack e18", 32'(ack), 32'd0);
        check_val("done pulse clr", 32'(done), 32'd0);
        @(negedge clk);
        check_val("pend ack e19", 32'(ack), 32'd0);
        @(negedge clk);
        check_val("pend ack e20", 32'(ack), 32'd1);
        check_val("pend rdata", 32'(rdata), 32'(CV));
        req = 1'b0;

        // Every location reads back the fill value.
        for (int i = 0; i < (1 << AW); i++) begin
            do_access(1'b0, AW'(i), 8'h00, "rd clr", rd);
            check_val("rd clr val", 32'(rd), 32'(CV));
        end

        // Write followed by reads.
        do_access(1'b1, 4'd7, 8'h3C, "wr7", rd);
        check_val("wr7 echo", 32'(rd), 32'h3C);
        @(negedge clk);
        check_val("ack one cycle", 32'(ack), 32'd0);
        do_access(1'b0, 4'd7, 8'h00, "rd7", rd);
        check_val("rd7 val", 32'(rd), 32'h3C);
        do_access(1'b0, 4'd6, 8'h00, "rd6", rd);
        check_val("rd6 val", 32'(rd), 32'(CV));

        // clear_start and req together: the fill wins, then the write is served.
        clear_start = 1'b1;
        req         = 1'b1;
        we          = 1'b1;
        addr        = 4'd2;
        wdata       = 8'h77;
        check_fill("fill1");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 50);
        check_val("post fill ack lat", 32'(n), 32'd3);
        check_val("post fill echo", 32'(rdata), 32'h77);
        req = 1'b0;
        do_access(1'b0, 4'd2, 8'h00, "rd2", rd);
        check_val("rd2 val", 32'(rd), 32'h77);
        do_access(1'b0, 4'd7, 8'h00, "rd7 cleared", rd);
        check_val("rd7 cleared val", 32'(rd), 32'(CV));

        // Reset pulsed mid-fill at address 9.
        clear_start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            clear_start = 1'b0;
            n++;
        end while (ram_address != 4'd9 && n < 40);
        check_val("mid fill addr", 32'(ram_address), 32'd9);
        check_val("mid fill wren", 32'(ram_wren), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("async wren", 32'(ram_wren), 32'd0);
        check_val("async addr", 32'(ram_address), 32'd0);
        check_val("async busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        check_fill("fill2");

        // Top address.
        do_access(1'b1, 4'd15, 8'h11, "wr15", rd);
        check_val("wr15 echo", 32'(rd), 32'h11);
        check_val("wr15 ram addr", 32'(ram_address), 32'd15);
        do_access(1'b0, 4'd15, 8'h00, "rd15", rd);
        check_val("rd15 val", 32'(rd), 32'h11);
        do_access(1'b0, 4'd0, 8'h00, "rd0", rd);
        check_val("rd0 val", 32'(rd), 32'(CV));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
